// File: rtl/vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module  : vga_scan_reader
// Brief   : 640x480@60 scan-out of a 256x256 video RAM image (top-left, black
//           elsewhere); one pixel per two Clocks, two-stage aligned pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module vga_scan_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oReadAddress,
    input  logic [2:0]  iReadData,
    output logic        oVGA_R,
    output logic        oVGA_G,
    output logic        oVGA_B,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oFrameStart
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // At least 9 bits so the 8-bit address slice and IMG_W/IMG_H=256 always fit
    localparam int c_HW = ($clog2(c_H_TOTAL) > 9) ? $clog2(c_H_TOTAL) : 9;
    localparam int c_VW = ($clog2(c_V_TOTAL) > 9) ? $clog2(c_V_TOTAL) : 9;

    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_VIS    = c_HW'(H_VISIBLE);
    localparam logic [c_HW-1:0] c_H_IMG    = c_HW'(IMG_W);
    localparam logic [c_HW-1:0] c_HS_BEGIN = c_HW'(H_VISIBLE + H_FRONT);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_VIS    = c_VW'(V_VISIBLE);
    localparam logic [c_VW-1:0] c_V_IMG    = c_VW'(IMG_H);
    localparam logic [c_VW-1:0] c_VS_BEGIN = c_VW'(V_VISIBLE + V_FRONT);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic            r_phase;
    logic [c_HW-1:0] r_hcount;
    logic [c_VW-1:0] r_vcount;

    logic            r_in_img;
    logic            r_visible;
    logic            r_hs;
    logic            r_vs;
    logic            r_first;

    logic [15:0]     r_addr;
    logic [2:0]      r_rgb;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_frame_start;

    logic            w_tick;
    logic            w_in_img;
    logic            w_visible;
    logic            w_hs;
    logic            w_vs;
    logic            w_first;
    logic [15:0]     w_addr;

    assign w_tick    = r_phase;
    assign w_in_img  = (r_hcount < c_H_IMG) && (r_vcount < c_V_IMG);
    assign w_visible = (r_hcount < c_H_VIS) && (r_vcount < c_V_VIS);
    assign w_hs      = !((r_hcount >= c_HS_BEGIN) && (r_hcount < c_HS_END));
    assign w_vs      = !((r_vcount >= c_VS_BEGIN) && (r_vcount < c_VS_END));
    assign w_first   = (r_hcount == '0) && (r_vcount == '0);
    assign w_addr    = w_in_img ? {r_vcount[7:0], r_hcount[7:0]} : 16'd0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_phase  <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (w_tick) begin
                if (r_hcount == c_H_LAST) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == c_V_LAST) ? '0 : r_vcount + 1'b1;
                end else begin
                    r_hcount <= r_hcount + 1'b1;
                end
            end
        end
    end

    // Stage 1: issue the RAM read and carry the pixel attributes alongside it
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_addr    <= 16'd0;
            r_in_img  <= 1'b0;
            r_visible <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_first   <= 1'b0;
        end else if (w_tick) begin
            r_addr    <= w_addr;
            r_in_img  <= w_in_img;
            r_visible <= w_visible;
            r_hs      <= w_hs;
            r_vs      <= w_vs;
            r_first   <= w_first;
        end
    end

    // Stage 2: RAM data has had one full Clock to settle by the next tick
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_rgb         <= 3'b000;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick & r_first;
            if (w_tick) begin
                r_rgb   <= (r_in_img && r_visible) ? iReadData : 3'b000;
                r_hsync <= r_hs;
                r_vsync <= r_vs;
            end
        end
    end

    assign oReadAddress = r_addr;
    assign oVGA_R       = r_rgb[2];
    assign oVGA_G       = r_rgb[1];
    assign oVGA_B       = r_rgb[0];
    assign oHSync       = r_hsync;
    assign oVSync       = r_vsync;
    assign oFrameStart  = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_scan_reader
// Brief   : Scoreboard bench for vga_scan_reader on a scaled-down raster
//           (34x19 total, 8x6 image) so whole frames run in a few kClocks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_scan_reader;

    localparam int c_HV = 20;
    localparam int c_HF = 4;
    localparam int c_HS = 6;
    localparam int c_HB = 4;
    localparam int c_VV = 12;
    localparam int c_VF = 2;
    localparam int c_VS = 2;
    localparam int c_VB = 3;
    localparam int c_IW = 8;
    localparam int c_IH = 6;
    localparam int c_HT = c_HV + c_HF + c_HS + c_HB;
    localparam int c_VT = c_VV + c_VF + c_VS + c_VB;
    localparam int c_FRAME = 2 * c_HT * c_VT;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        int          h;
        int          v;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oReadAddress;
    logic [2:0]  iReadData;
    logic        oVGA_R;
    logic        oVGA_G;
    logic        oVGA_B;
    logic        oHSync;
    logic        oVSync;
    logic        oFrameStart;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_h      = 0;
    int   m_v      = 0;
    logic m_phase  = 1'b0;
    int   cyc      = 0;
    logic ram_force = 1'b0;
    logic [2:0] ram_q = 3'b000;

    always #5 Clock = ~Clock;

    vga_scan_reader #(
        .H_VISIBLE(c_HV), .H_FRONT(c_HF), .H_SYNC(c_HS), .H_BACK(c_HB),
        .V_VISIBLE(c_VV), .V_FRONT(c_VF), .V_SYNC(c_VS), .V_BACK(c_VB),
        .IMG_W(c_IW), .IMG_H(c_IH)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .oReadAddress(oReadAddress),
        .iReadData   (iReadData),
        .oVGA_R      (oVGA_R),
        .oVGA_G      (oVGA_G),
        .oVGA_B      (oVGA_B),
        .oHSync      (oHSync),
        .oVSync      (oVSync),
        .oFrameStart (oFrameStart)
    );

    // Synchronous RAM with one Clock of read latency
    always @(posedge Clock) ram_q <= ram_force ? 3'b111 : oReadAddress[2:0];
    assign iReadData = ram_q;

    task automatic chk(input string name, input int h, input int v,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act === req) n_pass = n_pass + 1;
        else $display("FAIL %s (h=%0d v=%0d): got %0h, expected %0h", name, h, v, act, req);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"},  -1, -1, 32'(oReadAddress), 32'h0);
        chk({tag, "_rgb"},   -1, -1, 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h0);
        chk({tag, "_hsync"}, -1, -1, 32'(oHSync), 32'h1);
        chk({tag, "_vsync"}, -1, -1, 32'(oVSync), 32'h1);
        chk({tag, "_fs"},    -1, -1, 32'(oFrameStart), 32'h0);
    endtask

    function automatic exp_t expect_pixel(input int h, input int v);
        exp_t e;
        logic in_img;
        logic vis;
        in_img = (h < c_IW) && (v < c_IH);
        vis    = (h < c_HV) && (v < c_VV);
        e.h    = h;
        e.v    = v;
        e.addr = in_img ? 16'(v * 256 + h) : 16'h0000;
        e.rgb  = (in_img && vis) ? (ram_force ? 3'b111 : 3'(h % 8)) : 3'b000;
        e.hs   = !((h >= c_HV + c_HF) && (h < c_HV + c_HF + c_HS));
        e.vs   = !((v >= c_VV + c_VF) && (v < c_VV + c_VF + c_VS));
        e.fs   = (h == 0) && (v == 0);
        return e;
    endfunction

    // Issue side: on every expected pixel tick, queue the response for the
    // raster position the DUT counters hold at that edge.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_phase = 1'b0;
            m_h     = 0;
            m_v     = 0;
            cyc     = 0;
            exp_q.delete();
        end else begin
            cyc = cyc + 1;
            if (m_phase) begin
                exp_q.push_back(expect_pixel(m_h, m_v));
                if (m_h == c_HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == c_VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
            m_phase = ~m_phase;
        end
    end

    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    logic prev_fs = 1'b0;
    int   hs_fall = -1;
    int   vs_fall = -1;
    int   fs_last = -1;
    int   line0   = -1;

    // Monitor: a pixel leaves the pipeline one tick after it was queued
    always @(negedge Clock) begin
        exp_t e;
        if (Reset) begin
            prev_hs = 1'b1;
            prev_vs = 1'b1;
            prev_fs = 1'b0;
            hs_fall = -1;
            vs_fall = -1;
            fs_last = -1;
            line0   = -1;
        end else begin
            if (!m_phase && exp_q.size() >= 1) begin
                chk("read_addr", exp_q[$].h, exp_q[$].v, 32'(oReadAddress), 32'(exp_q[$].addr));
                if (exp_q.size() >= 2) begin
                    e = exp_q.pop_front();
                    chk("rgb",   e.h, e.v, 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(e.rgb));
                    chk("hsync", e.h, e.v, 32'(oHSync), 32'(e.hs));
                    chk("vsync", e.h, e.v, 32'(oVSync), 32'(e.vs));
                    chk("frame_start", e.h, e.v, 32'(oFrameStart), 32'(e.fs));
                    if (e.h == 0) line0 = cyc;
                end
            end else if (m_phase && exp_q.size() >= 1) begin
                chk("frame_start_one_clock", -1, -1, 32'(oFrameStart), 32'h0);
            end

            if (prev_hs && !oHSync) begin
                if (hs_fall >= 0) chk("hsync_period", -1, -1, 32'(cyc - hs_fall), 32'(2 * c_HT));
                if (line0 >= 0) chk("hsync_fall_after_pix0", -1, -1, 32'(cyc - line0), 32'(2 * (c_HV + c_HF)));
                hs_fall = cyc;
            end
            if (!prev_hs && oHSync && hs_fall >= 0)
                chk("hsync_low_width", -1, -1, 32'(cyc - hs_fall), 32'(2 * c_HS));

            if (prev_vs && !oVSync) begin
                if (vs_fall >= 0) chk("vsync_period", -1, -1, 32'(cyc - vs_fall), 32'(c_FRAME));
                if (fs_last >= 0) chk("vsync_fall_line", -1, -1, 32'(cyc - fs_last), 32'(2 * c_HT * (c_VV + c_VF)));
                vs_fall = cyc;
            end
            if (!prev_vs && oVSync && vs_fall >= 0)
                chk("vsync_low_width", -1, -1, 32'(cyc - vs_fall), 32'(2 * c_HT * c_VS));

            if (!prev_fs && oFrameStart) begin
                if (fs_last < 0) chk("frame_start_first", -1, -1, 32'(cyc), 32'd4);
                else chk("frame_start_period", -1, -1, 32'(cyc - fs_last), 32'(c_FRAME));
                fs_last = cyc;
            end

            prev_hs = oHSync;
            prev_vs = oVSync;
            prev_fs = oFrameStart;
        end
    end

    initial begin
        logic found;
        repeat (5) @(posedge Clock);
        #1 check_reset("por");
        #1 Reset = 1'b0;

        // Pattern RAM for two full frames
        repeat (2 * c_FRAME + 60) @(posedge Clock);

        // Mid-frame reset while an in-image pixel is in flight
        found = 1'b0;
        for (int i = 0; i < c_FRAME + 10 && !found; i++) begin
            @(posedge Clock);
            #1;
            if (m_h == 5 && m_v == 4) found = 1'b1;
        end
        chk("midframe_point_reached", -1, -1, 32'(found), 32'h1);
        chk("pre_reset_addr", -1, -1, 32'(oReadAddress), 32'h0404);
        #1 Reset = 1'b1;
        #1 check_reset("async");
        ram_force = 1'b1;
        repeat (3) @(posedge Clock);
        #2 Reset = 1'b0;

        // Forced-white RAM for a full frame
        repeat (c_FRAME + 100) @(posedge Clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
